// File: rtl/rf_wb_arb.sv
// rf_wb_arb: write-back arbiter and register scoreboard for the single
// register-file write port. Grants one requester per cycle (round-robin by
// default), registers the write, and tracks in-flight destination registers.
// Optional build macro: RF_WB_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) instead of round-robin.
module rf_wb_arb #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned RFW  = 5,
    parameter int unsigned DW   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*RFW-1:0]     req_reg,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic                    rf_we,
    output logic [RFW-1:0]          rf_wreg,
    output logic [DW-1:0]           rf_wdata,
    input  logic                    mark_valid,
    input  logic [RFW-1:0]          mark_reg,
    input  logic [RFW-1:0]          q1_reg,
    input  logic [RFW-1:0]          q2_reg,
    output logic                    q1_busy,
    output logic                    q2_busy,
    output logic [(1<<RFW)-1:0]     pending
);

    localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NPEND = 1 << RFW;

    logic [PW-1:0]    w_ptr;
    logic [PW-1:0]    w_cand;
    logic [PW-1:0]    w_win;
    logic             w_found;
    logic [RFW-1:0]   w_xreg;
    logic [DW-1:0]    w_xdata;
    logic [NPEND-1:0] w_pend_nxt;

    logic             r_we;
    logic [RFW-1:0]   r_wreg;
    logic [DW-1:0]    r_wdata;
    logic [NPEND-1:0] r_pend;

`ifdef RF_WB_ARB_FIXED_PRIO_EN
    // Fixed priority: the search always starts at requester 0.
    assign w_ptr = '0;
`else
    logic [PW-1:0] r_ptr;

    // Round-robin pointer moves just past the requester that transferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= PW'((32'(w_win) + 32'd1) % NREQ);
        end
    end

    assign w_ptr = r_ptr;
`endif

    // Winner is the first valid requester searching from the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_cand = PW'((32'(w_ptr) + k) % NREQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign req_ready = w_found ? (NREQ'(1) << w_win) : '0;
    assign w_xreg    = req_reg[32'(w_win)*RFW +: RFW];
    assign w_xdata   = req_data[32'(w_win)*DW +: DW];

    // Scoreboard next state: transfer clears, a new mark sets (and wins ties).
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_found) begin
            w_pend_nxt[w_xreg] = 1'b0;
        end
        if (mark_valid && (mark_reg != '0)) begin
            w_pend_nxt[mark_reg] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    // Registered write port and scoreboard bitmap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
            r_pend  <= '0;
        end else begin
            r_we <= w_found && (w_xreg != '0);
            if (w_found) begin
                r_wreg  <= w_xreg;
                r_wdata <= w_xdata;
            end
            r_pend <= w_pend_nxt;
        end
    end

    assign rf_we    = r_we;
    assign rf_wreg  = r_wreg;
    assign rf_wdata = r_wdata;
    assign pending  = r_pend;

    // A registered write that the register file has not yet committed still counts as busy.
    assign q1_busy = r_pend[q1_reg] | (r_we && (r_wreg == q1_reg) && (q1_reg != '0));
    assign q2_busy = r_pend[q2_reg] | (r_we && (r_wreg == q2_reg) && (q2_reg != '0));

endmodule

// File: tb/tb_rf_wb_arb.sv
// Testbench for rf_wb_arb: directed vectors with literal expectations plus a
// behavioural model compared against every output on each negedge.
module tb_rf_wb_arb;

    localparam int NREQ = 3;
    localparam int RFW  = 5;
    localparam int DW   = 32;
    localparam int NP   = 1 << RFW;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*RFW-1:0] req_reg;
    logic [NREQ*DW-1:0]  req_data;
    logic                rf_we;
    logic [RFW-1:0]      rf_wreg;
    logic [DW-1:0]       rf_wdata;
    logic                mark_valid;
    logic [RFW-1:0]      mark_reg;
    logic [RFW-1:0]      q1_reg;
    logic [RFW-1:0]      q2_reg;
    logic                q1_busy;
    logic                q2_busy;
    logic [NP-1:0]       pending;

    int n_chk = 0;
    int n_err = 0;

    rf_wb_arb #(.NREQ(NREQ), .RFW(RFW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_reg(req_reg), .req_data(req_data),
        .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
        .mark_valid(mark_valid), .mark_reg(mark_reg),
        .q1_reg(q1_reg), .q2_reg(q2_reg),
        .q1_busy(q1_busy), .q2_busy(q2_busy),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int              m_ptr;
    bit              m_pend [NP];
    bit              m_we;
    int              m_wreg;
    logic [DW-1:0]   m_wdata;

    // Index of the requester that gets the port, or -1 if none is asking.
    function automatic int pick(input logic [NREQ-1:0] v, input int p);
`ifdef RF_WB_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
        for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
        return -1;
    endfunction

    function automatic bit busy_of(input int q);
        return m_pend[q] || (m_we && m_wreg == q && q != 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr = 0; m_we = 0; m_wreg = 0; m_wdata = '0;
            for (int r = 0; r < NP; r++) m_pend[r] = 0;
        end else begin
            int w;
            int r;
            w = pick(req_valid, m_ptr);
            if (w >= 0) begin
                r       = int'(req_reg[w*RFW +: RFW]);
                m_ptr   = (w + 1) % NREQ;
                m_we    = (r != 0);
                m_wreg  = r;
                m_wdata = req_data[w*DW +: DW];
                m_pend[r] = 0;
            end else begin
                m_we = 0;
            end
            if (mark_valid && mark_reg != 0) m_pend[int'(mark_reg)] = 1;
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        int w;
        logic [NREQ-1:0] er;
        logic [NP-1:0]   ep;
        w  = pick(req_valid, m_ptr);
        er = '0;
        if (w >= 0) er[w] = 1'b1;
        for (int r = 0; r < NP; r++) ep[r] = m_pend[r];
        chk("m_ready", 64'(req_ready), 64'(er));
        chk("m_we", 64'(rf_we), 64'(m_we));
        chk("m_wreg", 64'(rf_wreg), 64'(m_wreg));
        chk("m_wdata", 64'(rf_wdata), 64'(m_wdata));
        chk("m_pending", 64'(pending), 64'(ep));
        chk("m_q1_busy", 64'(q1_busy), 64'(busy_of(int'(q1_reg))));
        chk("m_q2_busy", 64'(q2_busy), 64'(busy_of(int'(q2_reg))));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [RFW-1:0] r, input logic [DW-1:0] d);
        req_reg[i*RFW +: RFW] = r;
        req_data[i*DW +: DW]  = d;
    endtask

`ifdef RF_WB_ARB_FIXED_PRIO_EN
    localparam logic [NREQ-1:0] ORDER [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
    localparam logic [NREQ-1:0] PRE_RST_READY = 3'b001;
`else
    localparam logic [NREQ-1:0] ORDER [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    localparam logic [NREQ-1:0] PRE_RST_READY = 3'b100;
`endif

    initial begin
        rst_n = 1'b0; req_valid = '0; req_reg = '0; req_data = '0;
        mark_valid = 1'b0; mark_reg = '0; q1_reg = 5'd5; q2_reg = 5'd9;
        #2;
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_wreg", 64'(rf_wreg), 64'd0);
        chk("rst_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        #1 rst_n = 1'b1;

        // Single request from requester 1.
        tick();
        req_valid = 3'b010; set_req(1, 5'd7, 32'hDEAD_BEEF);
        #1 chk("single_ready", 64'(req_ready), 64'b010);
        tick();
        req_valid = '0;
        #1;
        chk("single_we", 64'(rf_we), 64'd1);
        chk("single_wreg", 64'(rf_wreg), 64'd7);
        chk("single_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
        tick();
        chk("single_we_drop", 64'(rf_we), 64'd0);

        // All three continuously valid from a fresh reset.
        rst_n = 1'b0; #1 rst_n = 1'b1;
        set_req(0, 5'd1, 32'h1111_0000);
        set_req(1, 5'd2, 32'h2222_0000);
        set_req(2, 5'd3, 32'h3333_0000);
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1 chk($sformatf("order_%0d", c), 64'(req_ready), 64'(ORDER[c]));
            tick();
            chk($sformatf("order_we_%0d", c), 64'(rf_we), 64'd1);
        end
        req_valid = '0;
        tick();

        // Write to r0 from requester 2 is accepted and discarded.
        req_valid = 3'b100; set_req(2, 5'd0, 32'hBAD0_0000);
        #1 chk("r0_ready", 64'(req_ready), 64'b100);
        tick();
        req_valid = '0;
        chk("r0_we", 64'(rf_we), 64'd0);
        chk("r0_pending", 64'(pending), 64'd0);

        // Mark r5 at cycle k, transfer to r5 at k+3.
        mark_valid = 1'b1; mark_reg = 5'd5;
        tick();
        mark_valid = 1'b0;
        #1;
        chk("mark_pending", 64'(pending), 64'h20);
        chk("mark_busy", 64'(q1_busy), 64'd1);
        tick();
        tick();
        chk("mark_busy_k2", 64'(q1_busy), 64'd1);
        req_valid = 3'b001; set_req(0, 5'd5, 32'h5555_5555);
        tick();
        req_valid = '0;
        #1;
        chk("clr_pending", 64'(pending), 64'd0);
        chk("clr_busy_held", 64'(q1_busy), 64'd1);
        chk("clr_we", 64'(rf_we), 64'd1);
        tick();
        chk("clr_busy_drop", 64'(q1_busy), 64'd0);

        // Mark r9 and transfer to r9 in the same edge: set wins.
        mark_valid = 1'b1; mark_reg = 5'd9;
        req_valid = 3'b001; set_req(0, 5'd9, 32'h9999_9999);
        tick();
        mark_valid = 1'b0; req_valid = '0;
        #1;
        chk("tie_pending", 64'(pending), 64'h200);
        chk("tie_q2_busy", 64'(q2_busy), 64'd1);

        // Build pending = 0x220 with a live write, then reset asynchronously.
        mark_valid = 1'b1; mark_reg = 5'd5;
        tick();
        mark_valid = 1'b0;
        req_valid = 3'b001; set_req(0, 5'd3, 32'h0303_0303);
        tick();
        req_valid = 3'b101; set_req(2, 5'd4, 32'h0404_0404);
        #1;
        chk("pre_rst_we", 64'(rf_we), 64'd1);
        chk("pre_rst_pending", 64'(pending), 64'h220);
        chk("pre_rst_ready", 64'(req_ready), 64'(PRE_RST_READY));
        rst_n = 1'b0;
        #1;
        chk("arst_we", 64'(rf_we), 64'd0);
        chk("arst_pending", 64'(pending), 64'd0);
        rst_n = 1'b1;
        #1 chk("post_rst_ready", 64'(req_ready), 64'b001);
        tick();
        req_valid = '0;
        chk("post_rst_wreg", 64'(rf_wreg), 64'd3);
        chk("post_rst_wdata", 64'(rf_wdata), 64'h0303_0303);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rf_wb_arb.md
# rf_wb_arb

Write-back arbiter and register scoreboard for the register file's single write port. Up to NREQ execution units (ALU, load unit, multiplier, …) present write-back requests with a valid/ready handshake. The block grants one per cycle and drives a registered write port into the register file. It also tracks in-flight destination registers so that decode can stall on read-after-write hazards.

## Interface
- NREQ, 3, number of write-back requesters (2..8)
- RFW, 5, register index width
- DW, 32, data width
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester write-back request
- req_ready  out  NREQ  per-requester grant; combinational, at most one bit high
- req_reg  in  NREQ*RFW  destination index, requester i at [i*RFW +: RFW]
- req_data  in  NREQ*DW  write data, requester i at [i*DW +: DW]
- rf_we  out  1  registered write enable to register file
- rf_wreg  out  RFW  registered write index
- rf_wdata  out  DW  registered write data
- mark_valid  in  1  decode issued an instruction with a destination
- mark_reg  in  RFW  that destination
- q1_reg, q2_reg  in  RFW  source registers queried by decode
- q1_busy, q2_busy  out  1  combinational: queried register is pending
- pending  out  2**RFW  scoreboard bitmap, registered

## Operation
- Arbitration:
  - Round-robin pointer `ptr` (width clog2(NREQ)).
  - Winner = first i with req_valid[i] set, searching ptr, ptr+1, … modulo NREQ.
  - req_ready[winner] = 1. All other ready bits are 0. All ready bits are 0 when no request is valid.
- Handshake: a transfer occurs on a posedge where req_valid[i] & req_ready[i].
  - A requester holds req_reg and req_data stable while valid and not ready.
  - A requester must not drop valid before it is granted.
- On a transfer from requester i:
  - `ptr` becomes (i+1) mod NREQ.
  - rf_wreg and rf_wdata are loaded from requester i.
  - rf_we is set to (req_reg_i != 0).
  - A write to r0 is accepted and discarded.
- No transfer: rf_we = 0. rf_wreg and rf_wdata hold their previous values.
- Scoreboard updates, per posedge:
  - A transfer to register r clears pending[r].
  - mark_valid with mark_reg = r ≠ 0 sets pending[r].
  - If the clear and the set hit the same r in one edge, the set wins, because a new producer was issued.
  - mark_reg = 0 is ignored. pending[0] is always 0.
- Hazard query: qN_busy = pending[qN_reg] | (rf_we & rf_wreg == qN_reg & qN_reg ≠ 0).
  - The second term covers a write that is registered but not yet committed by the register file.

## Timing
- Reset (asynchronous, any time, including mid-transfer):
  - ptr = 0, rf_we = 0, rf_wreg = 0, rf_wdata = 0, pending = 0.
  - req_ready follows from the inputs with ptr = 0.
  - A request in progress is lost. The requester re-presents it after reset.
- Latency:
  - A transfer at posedge k gives rf_we/rf_wreg/rf_wdata valid from just after posedge k until posedge k+1.
  - The register file commits on the negedge inside that cycle.
  - A read of that register returns the new value from that negedge onward.
- Throughput: one write per cycle. When all NREQ requesters are continuously valid, each is granted once every NREQ cycles.
- req_ready has no dependency on any output of this block within the same cycle. There is no combinational loop through the requesters.
- pending updates at posedge k. qN_busy reflects the updated bitmap from k onward.

## Configuration
- RF_WB_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority, lowest index wins. `ptr` is not implemented and is treated as 0. Starvation of higher indices is accepted.
  - Undefined (default): round-robin as specified above.

## Test plan
- Reset, then single request: req_valid=3'b010, req_reg1=7, req_data1=32'hDEAD_BEEF.
  - req_ready=3'b010 combinationally.
  - Next cycle rf_we=1, rf_wreg=7, rf_wdata=DEADBEEF. The cycle after that, rf_we=0.
- All three valid for 6 cycles from reset: grant order 0,1,2,0,1,2. rf_we high for all 6 cycles.
  - With RF_WB_ARB_FIXED_PRIO_EN: 0,0,0,0,0,0.
- Requester 2 writes r0: transfer completes with req_ready[2]=1, rf_we stays 0, pending unchanged.
- mark_reg=5 at cycle k:
  - pending[5]=1 and q1_busy=1 for q1_reg=5.
  - Transfer to r5 at cycle k+3: pending[5]=0 after k+3, but q1_busy stays 1 through cycle k+3 via the rf_we term, then drops to 0.
- Simultaneous mark_reg=9 and transfer to r9 in the same cycle: pending[9] remains 1.
- Assert rst_n=0 asynchronously while rf_we=1 and pending=32'h0000_0220:
  - Immediately rf_we=0, pending=0.
  - After release, the first grant goes to the lowest valid index.
